// File: rtl/aes_noc16_pkg.sv
// Shared NOC16 command codes, word widths and the result-pairing FSM state type.
package aes_noc16_pkg;

    localparam logic [7:0] CMD_RK     = 8'd0;
    localparam logic [7:0] CMD_IV     = 8'd1;
    localparam logic [7:0] CMD_DATA   = 8'd2;
    localparam logic [7:0] CMD_RESULT = 8'hFF;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HIGH = 2'd1,
        ST_SKIP = 2'd2
    } pair_state_t;

endpackage

// File: rtl/aes_noc16_collector_sync_fifo.sv
// Synchronous FIFO with registered first-word-fall-through head, level and status flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ready,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     not_full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_c;
    logic             push_ok_c;
    logic [AW-1:0]    rd_nxt_c;
    logic [LW-1:0]    level_nxt_c;
    logic [WIDTH-1:0] head_nxt_c;

    // Fullness uses the pre-cycle level so a same-cycle pop never frees a slot early.
    always_comb begin
        pop_c       = valid && ready;
        push_ok_c   = push && (level != LW'(DEPTH));
        rd_nxt_c    = rd_ptr + AW'(pop_c);
        level_nxt_c = level + LW'(push_ok_c) - LW'(pop_c);
        head_nxt_c  = (push_ok_c && (wr_ptr == rd_nxt_c)) ? wdata : mem[rd_nxt_c];
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            valid    <= 1'b0;
            not_full <= 1'b1;
            rdata    <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_nxt_c;
            level    <= level_nxt_c;
            valid    <= (level_nxt_c != '0);
            not_full <= (level_nxt_c != LW'(DEPTH));
            if (level_nxt_c != '0) begin
                rdata <= head_nxt_c;
            end
        end
    end

endmodule

// File: rtl/aes_noc16_collector.sv
// Pairs 64-bit accelerator result words into 128-bit blocks and streams them out via a FIFO.
// Optional statistics counters are built when AES_COLLECT_STATS_EN is defined.
module aes_noc16_collector
    import aes_noc16_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [7:0]  CMD_RESULT = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [63:0]             in_lo,
    input  logic [7:0]              in_cmd,
    input  logic                    in_valid,
    output logic                    in_rdy,
    output logic [127:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    cmd_error
`ifdef AES_COLLECT_STATS_EN
    ,
    output logic [31:0]             block_count,
    output logic [15:0]             drop_count
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    pair_state_t       state;
    logic [WORD_W-1:0] half;
    logic              is_result_c;
    logic              full_c;
    logic              push_c;

    always_comb begin
        is_result_c = in_valid && (in_cmd == CMD_RESULT);
        full_c      = (level == LW'(DEPTH));
        push_c      = is_result_c && (state == ST_HIGH) && !full_c;
    end

`ifdef AES_COLLECT_STATS_EN
    logic drop_c;

    // Any result word not latched or pushed is a loss: full FIFO, or the partner of a lost low word.
    always_comb begin
        drop_c = is_result_c && (full_c || (state == ST_SKIP));
    end
`endif

    // Pairing FSM and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOW;
            half      <= '0;
            overflow  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            if (in_valid && (in_cmd != CMD_RESULT)) begin
                cmd_error <= 1'b1;
            end
            if (is_result_c) begin
                case (state)
                    ST_LOW: begin
                        if (full_c) begin
                            overflow <= 1'b1;
                            state    <= ST_SKIP;
                        end else begin
                            half  <= in_lo;
                            state <= ST_HIGH;
                        end
                    end
                    ST_HIGH, ST_SKIP: begin
                        if (full_c) begin
                            overflow <= 1'b1;
                        end
                        state <= ST_LOW;
                    end
                    default: state <= ST_LOW;
                endcase
            end
        end
    end

`ifdef AES_COLLECT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            block_count <= '0;
            drop_count  <= '0;
        end else begin
            if (push_c) begin
                block_count <= block_count + 32'd1;
            end
            if (drop_c && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

    sync_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_c),
        .wdata    ({in_lo, half}),
        .ready    (out_ready),
        .rdata    (out_data),
        .valid    (out_valid),
        .not_full (in_rdy),
        .level    (level)
    );

endmodule

// File: tb/tb_aes_noc16_collector.sv
// Self-checking bench for aes_noc16_collector: queue-based reference model plus directed literal checks.
module tb_aes_noc16_collector;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  in_lo;
    logic [7:0]   in_cmd;
    logic         in_valid;
    logic         in_rdy;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   level;
    logic         overflow;
    logic         cmd_error;
`ifdef AES_COLLECT_STATS_EN
    logic [31:0]  block_count;
    logic [15:0]  drop_count;
`endif

    aes_noc16_collector #(.DEPTH(DEPTH), .CMD_RESULT(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_lo       (in_lo),
        .in_cmd      (in_cmd),
        .in_valid    (in_valid),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .cmd_error   (cmd_error)
`ifdef AES_COLLECT_STATS_EN
        ,
        .block_count (block_count),
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: block queue, a pending low word, and a "partner of a lost word" marker.
    logic [127:0] q[$];
    bit           m_half_v;
    logic [63:0]  m_half;
    bit           m_skip;
    bit           m_ovf;
    bit           m_cerr;
    logic [31:0]  m_blocks;
    logic [15:0]  m_drops;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_drop();
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    endfunction

    function automatic void model_step();
        bit full;
        bit pop;
        if (reset) begin
            q.delete();
            m_half_v = 0; m_half = '0; m_skip = 0;
            m_ovf = 0; m_cerr = 0; m_blocks = '0; m_drops = '0;
            return;
        end
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (in_valid && in_cmd != 8'hFF) m_cerr = 1;
        if (in_valid && in_cmd == 8'hFF) begin
            if (m_skip) begin
                model_drop();
                if (full) m_ovf = 1;
                m_skip = 0;
            end else if (!m_half_v) begin
                if (full) begin
                    model_drop(); m_ovf = 1; m_skip = 1;
                end else begin
                    m_half = in_lo; m_half_v = 1;
                end
            end else begin
                m_half_v = 0;
                if (full) begin
                    model_drop(); m_ovf = 1;
                end else begin
                    q.push_back({in_lo, m_half});
                    m_blocks = m_blocks + 32'd1;
                end
            end
        end
    endfunction

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            chk("level", 128'(level), 128'(q.size()));
            chk("in_rdy", 128'(in_rdy), 128'(q.size() < DEPTH));
            chk("overflow", 128'(overflow), 128'(m_ovf));
            chk("cmd_error", 128'(cmd_error), 128'(m_cerr));
            if (q.size() != 0) chk("out_data", out_data, q[0]);
`ifdef AES_COLLECT_STATS_EN
            chk("block_count", 128'(block_count), 128'(m_blocks));
            chk("drop_count", 128'(drop_count), 128'(m_drops));
`endif
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [7:0] c, input logic [63:0] lo, input bit rdy);
        reset = r; in_valid = v; in_cmd = c; in_lo = lo; out_ready = rdy;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic word(input logic [63:0] lo, input bit rdy);
        cyc(1'b0, 1'b1, 8'hFF, lo, rdy);
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 1'b0, 8'h00, 64'h0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
    endtask

    function automatic logic [127:0] blk(input int k);
        return {64'(16 * k + 1), 64'(16 * k)};
    endfunction

    initial begin
        int pct;
        do_reset();
        do_reset();
        chk_en = 1'b1;
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset in_rdy", 128'(in_rdy), 128'd1);
        chk("reset level", 128'(level), 128'd0);
        chk("reset overflow", 128'(overflow), 128'd0);

        // Basic pairing
        word(64'h1111, 1'b0);
        chk("pair early valid", 128'(out_valid), 128'd0);
        word(64'h2222, 1'b0);
        chk("pair valid", 128'(out_valid), 128'd1);
        chk("pair data", out_data, 128'h0000000000002222_0000000000001111);
        chk("pair level", 128'(level), 128'd1);

        // Fill to full, lose a pair, then drain in order
        do_reset();
        for (int k = 0; k < 4; k++) begin
            word(64'(16 * k), 1'b0);
            word(64'(16 * k + 1), 1'b0);
        end
        chk("full in_rdy", 128'(in_rdy), 128'd0);
        word(64'h99, 1'b0);
        word(64'h9A, 1'b0);
        chk("full overflow", 128'(overflow), 128'd1);
        chk("full level", 128'(level), 128'd4);
`ifdef AES_COLLECT_STATS_EN
        chk("full drop_count", 128'(drop_count), 128'd2);
        chk("full block_count", 128'(block_count), 128'd4);
`endif
        for (int k = 0; k < 4; k++) begin
            chk("drain order", out_data, blk(k));
            idle(1'b1);
        end
        chk("drain level", 128'(level), 128'd0);

        // Lost low word: its partner is discarded even after space frees
        do_reset();
        for (int k = 0; k < 4; k++) begin
            word(64'(16 * k), 1'b0);
            word(64'(16 * k + 1), 1'b0);
        end
        word(64'h77, 1'b0);
        idle(1'b1);
        word(64'h78, 1'b0);
        chk("skip level", 128'(level), 128'd3);
        word(64'hA0, 1'b0);
        word(64'hA1, 1'b0);
        chk("skip refill level", 128'(level), 128'd4);
`ifdef AES_COLLECT_STATS_EN
        chk("skip drop_count", 128'(drop_count), 128'd2);
`endif
        for (int k = 1; k < 4; k++) begin
            chk("skip drain", out_data, blk(k));
            idle(1'b1);
        end
        chk("skip new pair", out_data, 128'h00000000000000A1_00000000000000A0);
        idle(1'b1);

        // Foreign command between low and high
        do_reset();
        word(64'h5, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 64'hDEAD, 1'b0);
        chk("cmd_error set", 128'(cmd_error), 128'd1);
        word(64'h6, 1'b0);
        chk("cmd pair data", out_data, 128'h0000000000000006_0000000000000005);
        chk("cmd pair level", 128'(level), 128'd1);

        // Concurrent push and pop with a continuously ready consumer
        word(64'h7, 1'b0);
        word(64'h8, 1'b0);
        for (int k = 0; k < 8; k++) word(64'(32'hC000 + k), 1'b1);

        // Reset while holding a low word
        do_reset();
        word(64'hAAAA, 1'b0);
        do_reset();
        word(64'hBBBB, 1'b0);
        word(64'hCCCC, 1'b0);
        chk("reset-high data", out_data, 128'h000000000000CCCC_000000000000BBBB);
        chk("reset-high overflow", 128'(overflow), 128'd0);
        chk("reset-high cmd_error", 128'(cmd_error), 128'd0);
`ifdef AES_COLLECT_STATS_EN
        chk("reset-high block_count", 128'(block_count), 128'd1);
`endif

        // Randomized traffic with varying consumer pressure
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 500; i++) begin
                cyc($urandom_range(0, 399) == 0,
                    $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF,
                    {$urandom, $urandom},
                    $urandom_range(0, 99) < pct);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
